therm_to_bin: RTL

THERM_TO_BIN -- requirements
Module: therm_to_bin

---
 rtl/therm_pkg.sv | 19 +
 rtl/therm_bubble_fix.sv | 56 +++++
 rtl/therm_to_bin.sv | 111 +++++++++++
 3 files changed

// File: rtl/therm_pkg.sv
// -----------------------------------------------------------------------------
// therm_pkg
// Purpose : Shared constants for the thermometer-to-binary decoder slice.
//           Holds the default binary width and the width and ceiling of the
//           bubble error counter so the top level and the bench agree on them.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package therm_pkg;

    // Default binary output width; the thermometer input is 2**A_WIDTH-1 bits
    localparam int A_WIDTH_DEFAULT = 3;

    // Error counter width and its saturation ceiling
    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

    typedef logic [ERR_CNT_W-1:0] errCnt_t;

endpackage

// File: rtl/therm_bubble_fix.sv
// -----------------------------------------------------------------------------
// therm_bubble_fix
// Purpose : Purely combinational decode of one thermometer word. Each bit is
//           replaced by the majority of itself and its two neighbours (with a
//           virtual 1 below bit 0 and a virtual 0 above the top bit), the
//           corrected ones are counted to give the binary value, and the raw
//           word is flagged if any higher bit is set above a cleared bit.
// Ports   : i_code   - raw thermometer word, bit 0 = lowest threshold
//           o_bin    - number of ones in the corrected word
//           o_bubble - raw word contained at least one 0-below-1 bubble
// -----------------------------------------------------------------------------
module therm_bubble_fix
    import therm_pkg::*;
#(
    parameter int A_WIDTH = A_WIDTH_DEFAULT,
    parameter int T_WIDTH = 2**A_WIDTH-1
) (
    input  logic [T_WIDTH-1:0] i_code,
    output logic [A_WIDTH-1:0] o_bin,
    output logic               o_bubble
);

    logic [T_WIDTH+1:0] w_ext;
    logic [T_WIDTH-1:0] w_fixed;

    // Pad the word with the virtual boundary bits so every position has two
    // neighbours, then take a three-input majority at each position.
    always_comb begin
        w_ext   = {1'b0, i_code, 1'b1};
        w_fixed = '0;
        for (int i = 0; i < T_WIDTH; i++) begin
            w_fixed[i] = (w_ext[i]   & w_ext[i+1]) |
                         (w_ext[i]   & w_ext[i+2]) |
                         (w_ext[i+1] & w_ext[i+2]);
        end
    end

    // Population count of the corrected word. The maximum is T_WIDTH, which
    // always fits in A_WIDTH bits, so the accumulator never wraps.
    always_comb begin
        o_bin = '0;
        for (int i = 0; i < T_WIDTH; i++) begin
            o_bin = o_bin + A_WIDTH'(w_fixed[i]);
        end
    end

    // A bubble is any set bit sitting directly above a cleared bit in the raw
    // word; a clean thermometer code never has that pattern.
    always_comb begin
        o_bubble = 1'b0;
        for (int i = 0; i < T_WIDTH-1; i++) begin
            o_bubble = o_bubble | (i_code[i+1] & ~i_code[i]);
        end
    end

endmodule

// File: rtl/therm_to_bin.sv
// -----------------------------------------------------------------------------
// therm_to_bin
// Purpose : Two-stage valid/ready pipeline that converts a thermometer code
//           into a binary count with bubble correction. Stage 1 registers the
//           raw word; stage 2 registers the decoded value and bubble flag.
//           A saturating counter records how many bubble-corrected words have
//           entered the output stage.
// Ports   : clk, rst             - clock, synchronous active-high reset
//           t_in/t_valid/t_ready - upstream thermometer word handshake
//           bin_out/bin_bubble   - decoded value and bubble flag
//           bin_valid/bin_ready  - downstream handshake
//           clr_cnt              - synchronous clear of err_cnt (wins over count)
//           err_cnt              - saturating count of bubble words
// -----------------------------------------------------------------------------
module therm_to_bin
    import therm_pkg::*;
#(
    parameter int A_WIDTH = A_WIDTH_DEFAULT,
    parameter int T_WIDTH = 2**A_WIDTH-1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [T_WIDTH-1:0]   t_in,
    input  logic                 t_valid,
    output logic                 t_ready,
    output logic [A_WIDTH-1:0]   bin_out,
    output logic                 bin_bubble,
    output logic                 bin_valid,
    input  logic                 bin_ready,
    input  logic                 clr_cnt,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [T_WIDTH-1:0]   r_s1Code;
    logic                 r_s1Valid;
    logic [A_WIDTH-1:0]   r_binOut;
    logic                 r_binBubble;
    logic                 r_binValid;
    errCnt_t              r_errCnt;

    logic [A_WIDTH-1:0]   w_fixBin;
    logic                 w_fixBubble;
    logic                 w_s2Load;
    logic                 w_s1Load;

    therm_bubble_fix #(
        .A_WIDTH (A_WIDTH),
        .T_WIDTH (T_WIDTH)
    ) u_fix (
        .i_code   (r_s1Code),
        .o_bin    (w_fixBin),
        .o_bubble (w_fixBubble)
    );

    // Stage 2 takes the stage 1 word whenever the output slot is empty or is
    // being emptied this cycle. Stage 1 can accept when it is empty or when its
    // word is moving on, which gives one word per cycle with no bubbles.
    // Holding t_ready low during reset keeps upstream from seeing an accept
    // that the reset would immediately throw away.
    assign w_s2Load = r_s1Valid && (!r_binValid || bin_ready);
    assign t_ready  = !rst && (!r_s1Valid || w_s2Load);
    assign w_s1Load = t_valid && t_ready;

    // Stage 1: capture the raw thermometer word. The code register is only
    // written on accept; its contents are ignored while r_s1Valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1Code  <= '0;
        end else if (w_s1Load) begin
            r_s1Valid <= 1'b1;
            r_s1Code  <= t_in;
        end else if (w_s2Load) begin
            r_s1Valid <= 1'b0;
        end
    end

    // Stage 2: decoded value and bubble flag. When stalled nothing is written,
    // so the presented word stays put until the downstream takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_binValid  <= 1'b0;
            r_binOut    <= '0;
            r_binBubble <= 1'b0;
        end else if (w_s2Load) begin
            r_binValid  <= 1'b1;
            r_binOut    <= w_fixBin;
            r_binBubble <= w_fixBubble;
        end else if (bin_ready) begin
            r_binValid  <= 1'b0;
        end
    end

    // Error counter: one count per bubble word entering stage 2, sticking at
    // the ceiling. A clear in the same cycle as a count wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_errCnt <= '0;
        end else if (clr_cnt) begin
            r_errCnt <= '0;
        end else if (w_s2Load && w_fixBubble && (r_errCnt != ERR_CNT_MAX)) begin
            r_errCnt <= r_errCnt + 1'b1;
        end
    end

    assign bin_out    = r_binOut;
    assign bin_bubble = r_binBubble;
    assign bin_valid  = r_binValid;
    assign err_cnt    = r_errCnt;

endmodule
